// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin arbiter sharing one memory port between the I-side
//            (read-only) and D-side (read/write) requesters, with watchdog.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic        i_resp,
    output logic [31:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_resp,
    output logic [31:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp,
    input  logic [31:0] mem_rdata,
    output logic        err
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_WD_MAX = c_CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVE_I = 2'd1,
        S_SERVE_D = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last_d;
    logic               r_mem_read;
    logic               r_mem_write;
    logic [31:0]        r_mem_address;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_wmask;
    logic [c_CNT_W-1:0] r_wd_cnt;
    logic               r_err;

    logic               w_i_req;
    logic               w_d_req;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_serving;
    logic [c_CNT_W-1:0] w_wd_inc;

    assign w_i_req   = i_read;
    assign w_d_req   = d_read | d_write;
    assign w_serving = (r_state == S_SERVE_I) || (r_state == S_SERVE_D);
    assign w_wd_inc  = (r_wd_cnt == c_WD_MAX) ? r_wd_cnt : r_wd_cnt + c_CNT_W'(1);

    always_comb begin
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // On a tie, the side that did not win last time goes first.
                if (w_i_req && w_d_req) begin
                    w_grant_i = r_last_d;
                    w_grant_d = ~r_last_d;
                end else begin
                    w_grant_i = w_i_req;
                    w_grant_d = w_d_req;
                end
                if (w_grant_i) begin
                    w_state_nxt = S_SERVE_I;
                end else if (w_grant_d) begin
                    w_state_nxt = S_SERVE_D;
                end
            end
            S_SERVE_I, S_SERVE_D: begin
                if (mem_resp) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last_d      <= 1'b1;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_wmask   <= '0;
            r_wd_cnt      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_i) begin
                r_mem_read    <= 1'b1;
                r_mem_write   <= 1'b0;
                r_mem_address <= i_address;
                r_mem_wdata   <= '0;
                r_mem_wmask   <= '0;
                r_last_d      <= 1'b0;
                r_wd_cnt      <= '0;
            end else if (w_grant_d) begin
                // An illegal read+write request is served as a read.
                r_mem_read    <= d_read;
                r_mem_write   <= d_write & ~d_read;
                r_mem_address <= d_address;
                r_mem_wdata   <= d_wdata;
                r_mem_wmask   <= d_wmask;
                r_last_d      <= 1'b1;
                r_wd_cnt      <= '0;
            end else if (w_serving) begin
                if (mem_resp) begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end else begin
                    r_wd_cnt <= w_wd_inc;
                    if (w_wd_inc == c_WD_MAX) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign i_resp      = (r_state == S_SERVE_I) && mem_resp;
    assign d_resp      = (r_state == S_SERVE_D) && mem_resp;
    assign i_rdata     = (r_state == S_SERVE_I) ? mem_rdata : '0;
    assign d_rdata     = (r_state == S_SERVE_D) ? mem_rdata : '0;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wmask   = r_mem_wmask;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Scoreboard bench for mem_port_arbiter with a latency-programmable
//            memory responder. Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [31:0] c_XOR  = 32'h5A5A_0000;
    localparam logic [31:0] c_IDLE = 32'hCAFE_F00D;

    logic        clk;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic        i_resp;
    logic [31:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_resp;
    logic [31:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        err;

    mem_port_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_resp(mem_resp),
        .mem_rdata(mem_rdata), .err(err)
    );

    typedef struct {
        bit          side;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          n_push = 0;
    int          n_resp = 0;
    int          mem_lat = 1;
    bit          use_fixed = 0;
    logic [31:0] fixed_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input bit side, input logic [31:0] addr);
        exp_t e;
        e.side  = side;
        e.rdata = use_fixed ? fixed_data : (addr ^ c_XOR);
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit into the cycle after the last expected response.
    task automatic wait_resps();
        int b = 0;
        do begin
            @(posedge clk);
            b++;
        end while (n_resp < n_push && b < 100);
        #1;
        if (n_resp < n_push) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: got %0d responses expected %0d", n_resp, n_push);
            n_resp = n_push;
            exp_q.delete();
        end
    endtask

    // Memory model: answers in the mem_lat-th cycle a strobe is held high.
    initial begin
        int mcnt = 0;
        mem_resp  = 1'b0;
        mem_rdata = c_IDLE;
        forever begin
            @(posedge clk);
            #1;
            mem_resp  = 1'b0;
            mem_rdata = c_IDLE;
            if (mem_read || mem_write) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    mem_resp  = 1'b1;
                    mem_rdata = use_fixed ? fixed_data : (mem_address ^ c_XOR);
                    mcnt      = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every response.
    initial begin
        bit   prev_resp = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_resp = 0;
            end else begin
                if (prev_resp) check("strobe_drop", {30'd0, mem_read, mem_write}, 32'd0);
                if (i_resp && d_resp) check("dual_resp", 32'd1, 32'd0);
                if (i_resp || d_resp) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", {31'd0, d_resp}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_side", {31'd0, d_resp}, {31'd0, e.side});
                        check("resp_rdata", d_resp ? d_rdata : i_rdata, e.rdata);
                    end
                    n_resp++;
                end
                prev_resp = i_resp || d_resp;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0; d_wmask = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wmask", {28'd0, mem_wmask}, 32'd0);
        check("rst_err_resp", {29'd0, err, i_resp, d_resp}, 32'd0);
        cyc();
        rst = 1'b0;

        // Tie after reset: I, D, I, D.
        mem_lat = 1;
        i_read = 1'b1; i_address = 32'h200;
        d_read = 1'b1; d_address = 32'h300;
        push(0, 32'h200); push(1, 32'h300); push(0, 32'h200); push(1, 32'h300);
        wait_resps();
        i_read = 1'b0; d_read = 1'b0;
        cyc();

        // Single I read, 3-cycle memory.
        mem_lat = 3; use_fixed = 1; fixed_data = 32'hDEAD_BEEF;
        i_read = 1'b1; i_address = 32'h60;
        push(0, 32'h60);
        cyc();
        @(negedge clk);
        check("i_strobe_n1", {31'd0, mem_read}, 32'd1);
        check("i_addr", mem_address, 32'h60);
        check("i_wmask", {28'd0, mem_wmask}, 32'd0);
        check("i_wdata", mem_wdata, 32'd0);
        check("i_resp_n1", {31'd0, i_resp}, 32'd0);
        cyc();
        @(negedge clk);
        check("i_resp_n2", {31'd0, i_resp}, 32'd0);
        cyc();
        @(negedge clk);
        check("i_resp_n3", {31'd0, i_resp}, 32'd1);
        wait_resps();
        i_read = 1'b0; use_fixed = 0;
        cyc();

        // D write; wdata changes after grant must not leak through.
        mem_lat = 2;
        d_write = 1'b1; d_address = 32'h100; d_wdata = 32'h1122_3344; d_wmask = 4'b0101;
        push(1, 32'h100);
        cyc();
        d_wdata = 32'hFFFF_FFFF; d_wmask = 4'hF;
        @(negedge clk);
        check("d_strobes", {30'd0, mem_read, mem_write}, 32'd1);
        check("d_addr", mem_address, 32'h100);
        check("d_wdata", mem_wdata, 32'h1122_3344);
        check("d_wmask", {28'd0, mem_wmask}, 32'h5);
        cyc();
        @(negedge clk);
        check("d_resp_n2", {31'd0, d_resp}, 32'd1);
        check("d_wdata_held", mem_wdata, 32'h1122_3344);
        wait_resps();
        d_write = 1'b0;
        cyc();

        // Dropped I request still completes.
        mem_lat = 4;
        i_read = 1'b1; i_address = 32'h400;
        push(0, 32'h400);
        cyc();
        i_read = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("drop_strobe", {31'd0, mem_read}, 32'd1);
            cyc();
        end
        wait_resps();
        @(negedge clk);
        check("drop_idle", {30'd0, mem_read, mem_write}, 32'd0);
        cyc();

        // Reset during SERVE_D, then a tie must go to I.
        mem_lat = 100;
        d_write = 1'b1; d_address = 32'h500; d_wdata = 32'hA5; d_wmask = 4'hF;
        cyc();
        @(negedge clk);
        check("rmid_strobe", {31'd0, mem_write}, 32'd1);
        cyc();
        rst = 1'b1; d_write = 1'b0;
        @(negedge clk);
        check("rmid_no_resp", {31'd0, d_resp}, 32'd0);
        cyc();
        rst = 1'b0;
        mem_lat = 1;
        i_read = 1'b1; i_address = 32'h700;
        d_read = 1'b1; d_address = 32'h800;
        push(0, 32'h700); push(1, 32'h800);
        @(negedge clk);
        check("rmid_dropped", {30'd0, mem_read, mem_write}, 32'd0);
        check("rmid_resp0", {30'd0, i_resp, d_resp}, 32'd0);
        wait_resps();
        i_read = 1'b0; d_read = 1'b0;
        cyc();

        // Watchdog with TIMEOUT = 8.
        mem_lat = 20;
        d_read = 1'b1; d_address = 32'h600;
        push(1, 32'h600);
        repeat (8) cyc();
        @(negedge clk);
        check("wd_err_n8", {31'd0, err}, 32'd0);
        check("wd_i_rdata_gated", i_rdata, 32'd0);
        check("wd_d_rdata_pass", d_rdata, c_IDLE);
        check("wd_strobe", {31'd0, mem_read}, 32'd1);
        cyc();
        @(negedge clk);
        check("wd_err_n9", {31'd0, err}, 32'd1);
        wait_resps();
        d_read = 1'b0;
        @(negedge clk);
        check("wd_err_sticky", {31'd0, err}, 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        check("wd_err_cleared", {31'd0, err}, 32'd0);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
